// File: rtl/prio_enc_pipe.sv
// ============================================================================
// Module   : prio_enc_pipe
// Purpose  : Registered WIDTH-bit priority encoder with fixed-priority and
//            round-robin modes, and a fixed 2-cycle latency.
// Options  : PRIO_ENC_STATS_EN adds a saturating grant counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module prio_enc_pipe #(
  parameter int WIDTH = 16,
  parameter int MODE  = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in,
  input  logic                       enable,
`ifdef PRIO_ENC_STATS_EN
  input  logic                       cnt_clr,
  output logic [15:0]                grant_cnt,
`endif
  output logic [$clog2(WIDTH)-1:0]   binary_out,
  output logic                       valid_out,
  output logic                       multi_out
);

  localparam int IDX_W = $clog2(WIDTH);

  logic [WIDTH-1:0] r_in_reg;
  logic             r_en_reg;
  logic [IDX_W-1:0] w_sel;
  logic             w_act;
  logic             w_multi;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_in_reg <= '0;
      r_en_reg <= 1'b0;
    end else begin
      r_in_reg <= in;
      r_en_reg <= enable;
    end
  end

  assign w_act   = r_en_reg & (|r_in_reg);
  // x & (x-1) is non-zero exactly when two or more bits are set
  assign w_multi = r_en_reg & (|(r_in_reg & (r_in_reg - WIDTH'(1))));

  generate
    if (MODE == 1) begin : g_rr
      logic [IDX_W-1:0] r_rr_ptr;
      logic [IDX_W-1:0] w_scan_idx;
      logic             w_found;

      // WIDTH is a power of two, so IDX_W-bit addition wraps WIDTH-1 -> 0
      always_comb begin
        w_sel      = '0;
        w_found    = 1'b0;
        w_scan_idx = '0;
        for (int k = 0; k < WIDTH; k++) begin
          w_scan_idx = r_rr_ptr + IDX_W'(k);
          if (!w_found && r_in_reg[w_scan_idx]) begin
            w_sel   = w_scan_idx;
            w_found = 1'b1;
          end
        end
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_rr_ptr <= '0;
        end else if (w_act) begin
          r_rr_ptr <= w_sel + IDX_W'(1);
        end
      end
    end else begin : g_fixed
      always_comb begin
        w_sel = '0;
        for (int i = 0; i < WIDTH; i++) begin
          if (r_in_reg[i]) begin
            w_sel = IDX_W'(i);
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      binary_out <= '0;
      valid_out  <= 1'b0;
      multi_out  <= 1'b0;
    end else begin
      binary_out <= w_act ? w_sel : '0;
      valid_out  <= w_act;
      multi_out  <= w_multi;
    end
  end

`ifdef PRIO_ENC_STATS_EN
  // Clear takes precedence over a same-cycle grant
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_cnt <= '0;
    end else if (cnt_clr) begin
      grant_cnt <= '0;
    end else if (w_act && (grant_cnt != 16'hFFFF)) begin
      grant_cnt <= grant_cnt + 16'd1;
    end
  end
`else
  // Statistics counter not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_prio_enc_pipe.sv
// ============================================================================
// Module   : tb_prio_enc_pipe
// Purpose  : Directed self-checking bench for prio_enc_pipe, one instance per
//            MODE; covers reset, latency, priority, enable and round-robin.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_prio_enc_pipe;

  logic        clock;
  logic        reset;
  logic [15:0] in0, in1;
  logic        en0, en1;
  logic [3:0]  bin0, bin1;
  logic        valid0, valid1, multi0, multi1;
`ifdef PRIO_ENC_STATS_EN
  logic        clr0, clr1;
  logic [15:0] cnt0, cnt1;
`endif

  int n_asrt = 0;
  int n_fail = 0;

  prio_enc_pipe #(.WIDTH(16), .MODE(0)) dut_fixed (
    .clock      (clock),
    .reset      (reset),
    .in         (in0),
    .enable     (en0),
`ifdef PRIO_ENC_STATS_EN
    .cnt_clr    (clr0),
    .grant_cnt  (cnt0),
`endif
    .binary_out (bin0),
    .valid_out  (valid0),
    .multi_out  (multi0)
  );

  prio_enc_pipe #(.WIDTH(16), .MODE(1)) dut_rr (
    .clock      (clock),
    .reset      (reset),
    .in         (in1),
    .enable     (en1),
`ifdef PRIO_ENC_STATS_EN
    .cnt_clr    (clr1),
    .grant_cnt  (cnt1),
`endif
    .binary_out (bin1),
    .valid_out  (valid1),
    .multi_out  (multi1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk0(input string tag, input logic [3:0] b, input logic v, input logic m);
    chk({tag, ".bin"},   32'(bin0),   32'(b));
    chk({tag, ".valid"}, 32'(valid0), 32'(v));
    chk({tag, ".multi"}, 32'(multi0), 32'(m));
  endtask

  task automatic chk1(input string tag, input logic [3:0] b, input logic v, input logic m);
    chk({tag, ".bin"},   32'(bin1),   32'(b));
    chk({tag, ".valid"}, 32'(valid1), 32'(v));
    chk({tag, ".multi"}, 32'(multi1), 32'(m));
  endtask

  initial begin
    reset = 1'b1;
    in0 = '0; en0 = 1'b0; in1 = '0; en1 = 1'b0;
`ifdef PRIO_ENC_STATS_EN
    clr0 = 1'b0; clr1 = 1'b0;
`endif
    tick(); tick();
    chk0("reset_fixed", 4'd0, 1'b0, 1'b0);
    chk1("reset_rr",    4'd0, 1'b0, 1'b0);
    reset = 1'b0;

    // Fixed priority: highest bit wins, one cycle is not enough
    in0 = 16'h8421; en0 = 1'b1;
    tick();
    chk("lat_not_yet", 32'(valid0), 32'd0);
    tick();
    chk0("fix_8421", 4'd15, 1'b1, 1'b1);

    in0 = 16'h0001;
    tick(); tick();
    chk0("fix_0001", 4'd0, 1'b1, 1'b0);

    in0 = 16'h0F00;
    tick(); tick();
    chk0("fix_0F00", 4'd11, 1'b1, 1'b1);

    in0 = 16'hFFFF; en0 = 1'b0;
    tick(); tick();
    chk0("en_low", 4'd0, 1'b0, 1'b0);

    in0 = 16'h0000; en0 = 1'b1;
    tick(); tick();
    chk0("zero_in", 4'd0, 1'b0, 1'b0);

    // Asynchronous reset mid-stream
    in0 = 16'h0020;
    tick(); tick();
    chk0("pre_reset", 4'd5, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    chk0("async_reset", 4'd0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_lat", 32'(valid0), 32'd0);
    tick();
    chk0("post_rst_5", 4'd5, 1'b1, 1'b0);

    // Round-robin fairness with wrap, pointer starts at 0
    in1 = 16'h8011; en1 = 1'b1;
    tick();
    tick(); chk1("rr_g0",  4'd0,  1'b1, 1'b1);
    tick(); chk1("rr_g4",  4'd4,  1'b1, 1'b1);
    tick(); chk1("rr_g15", 4'd15, 1'b1, 1'b1);
    tick(); chk1("rr_g0b", 4'd0,  1'b1, 1'b1);
    en1 = 1'b0;
    tick(); chk1("rr_g4b", 4'd4,  1'b1, 1'b1);
    tick(); chk1("rr_off1", 4'd0, 1'b0, 1'b0);
    in1 = 16'h0011; en1 = 1'b1;
    tick(); chk1("rr_off2", 4'd0, 1'b0, 1'b0);
    tick(); chk1("rr_hold_wrap", 4'd0, 1'b1, 1'b1);
    in1 = 16'h0008;
    tick(); chk1("rr_g4c", 4'd4, 1'b1, 1'b1);
    tick(); chk1("rr_single", 4'd3, 1'b1, 1'b0);

`ifdef PRIO_ENC_STATS_EN
    en0 = 1'b0; en1 = 1'b0;
    tick(); tick();
    clr1 = 1'b1;
    tick();
    clr1 = 1'b0;
    chk("cnt_cleared", 32'(cnt1), 32'd0);
    in1 = 16'h0002; en1 = 1'b1;
    tick(); tick(); tick();
    en1 = 1'b0;
    tick(); tick();
    chk("cnt_3", 32'(cnt1), 32'd3);

    clr1 = 1'b1;
    tick();
    clr1 = 1'b0;
    en1 = 1'b1;
    // N ticks with enable held give N-1 grants after the pipeline fills
    for (int i = 0; i < 65535; i++) tick();
    chk("cnt_fffe", 32'(cnt1), 32'hFFFE);
    tick(); tick(); tick();
    chk("cnt_sat", 32'(cnt1), 32'hFFFF);
    clr1 = 1'b1;
    tick();
    clr1 = 1'b0;
    chk("cnt_clr_wins", 32'(cnt1), 32'd0);
    en1 = 1'b0;
    tick(); tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
